pll_reset_sequencer: RTL and testbench

PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

---
 rtl/pll_reset_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer
// Brings up the phi PLL, then the theta PLL, then releases the TDC. Each PLL
// reset is held for a fixed time and is then given a bounded time to lock.
// Lock timeouts are retried a limited number of times before the sequencer
// parks in ERROR. Once in RUN, a loss of lock sends the sequence back to the
// earliest stage that has to be redone.
//
// Ports
//   clk_clk          system clock, rising edge
//   reset_reset_n    asynchronous active-low reset
//   start            single-cycle bring-up request (honoured in IDLE and ERROR)
//   abort            single-cycle request to return to IDLE (highest priority)
//   phi_locked       phi PLL lock, asynchronous
//   theta_locked     theta PLL lock, asynchronous
//   phi_pll_reset    active-high reset to the phi PLL
//   theta_pll_reset  active-high reset to the theta PLL
//   tdc_reset        active-high reset to the TDC
//   ready            high only in RUN
//   error            high only in ERROR
//   state            current state (IDLE=0 ... ERROR=7)
//   retry_count      lock-timeout retries in the current bring-up
//   relock_count     lock losses seen in RUN, saturating at 255
module pll_reset_sequencer #(
    parameter int RST_CYCLES     = 16,
    parameter int LOCK_TIMEOUT   = 50000,
    parameter int TDC_RST_CYCLES = 32,
    parameter int MAX_RETRIES    = 3
) (
    input  logic       clk_clk,
    input  logic       reset_reset_n,
    input  logic       start,
    input  logic       abort,
    input  logic       phi_locked,
    input  logic       theta_locked,
    output logic       phi_pll_reset,
    output logic       theta_pll_reset,
    output logic       tdc_reset,
    output logic       ready,
    output logic       error,
    output logic [2:0] state,
    output logic [3:0] retry_count,
    output logic [7:0] relock_count
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_PHI_RST    = 3'd1,
        S_PHI_WAIT   = 3'd2,
        S_THETA_RST  = 3'd3,
        S_THETA_WAIT = 3'd4,
        S_TDC_RST    = 3'd5,
        S_RUN        = 3'd6,
        S_ERROR      = 3'd7
    } seq_state_t;

    // The cycle counter is wide enough for the largest legal lock timeout.
    // Each timed state ends on the cycle its counter reaches the last index.
    localparam logic [19:0] RST_LAST    = 20'(RST_CYCLES - 1);
    localparam logic [19:0] LOCK_LAST   = 20'(LOCK_TIMEOUT - 1);
    localparam logic [19:0] TDC_LAST    = 20'(TDC_RST_CYCLES - 1);
    localparam logic [3:0]  RETRY_LIMIT = 4'(MAX_RETRIES);

    seq_state_t  state_q;
    seq_state_t  state_d;
    logic [19:0] cycle_cnt;
    logic [3:0]  retry_d;
    logic [7:0]  relock_d;
    logic        phi_meta;
    logic        phi_sync;
    logic        theta_meta;
    logic        theta_sync;

    // Two-flop synchronizers for the asynchronous lock indicators. Every
    // decision below uses only the *_sync copies.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            phi_meta   <= 1'b0;
            phi_sync   <= 1'b0;
            theta_meta <= 1'b0;
            theta_sync <= 1'b0;
        end else begin
            phi_meta   <= phi_locked;
            phi_sync   <= phi_meta;
            theta_meta <= theta_locked;
            theta_sync <= theta_meta;
        end
    end

    // Next-state logic. abort overrides everything. In the stages after phi
    // has locked, losing phi always restarts from PHI_RST, which is why that
    // check comes before theta lock and before timer expiry.
    always_comb begin
        state_d  = state_q;
        retry_d  = retry_count;
        relock_d = relock_count;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_PHI_RST;
                        retry_d = 4'd0;
                    end
                end
                S_PHI_RST: begin
                    if (cycle_cnt == RST_LAST) state_d = S_PHI_WAIT;
                end
                S_PHI_WAIT: begin
                    if (phi_sync) begin
                        state_d = S_THETA_RST;
                    end else if (cycle_cnt == LOCK_LAST) begin
                        if (retry_count < RETRY_LIMIT) begin
                            state_d = S_PHI_RST;
                            retry_d = retry_count + 4'd1;
                        end else begin
                            state_d = S_ERROR;
                        end
                    end
                end
                S_THETA_RST: begin
                    if (!phi_sync)                    state_d = S_PHI_RST;
                    else if (cycle_cnt == RST_LAST)   state_d = S_THETA_WAIT;
                end
                S_THETA_WAIT: begin
                    if (!phi_sync) begin
                        state_d = S_PHI_RST;
                    end else if (theta_sync) begin
                        state_d = S_TDC_RST;
                    end else if (cycle_cnt == LOCK_LAST) begin
                        if (retry_count < RETRY_LIMIT) begin
                            state_d = S_THETA_RST;
                            retry_d = retry_count + 4'd1;
                        end else begin
                            state_d = S_ERROR;
                        end
                    end
                end
                S_TDC_RST: begin
                    if (!phi_sync)                    state_d = S_PHI_RST;
                    else if (!theta_sync)             state_d = S_THETA_RST;
                    else if (cycle_cnt == TDC_LAST)   state_d = S_RUN;
                end
                S_RUN: begin
                    // A loss in RUN is a fresh bring-up as far as retries go.
                    if (!phi_sync || !theta_sync) begin
                        state_d = !phi_sync ? S_PHI_RST : S_THETA_RST;
                        retry_d = 4'd0;
                        if (relock_count != 8'hFF) relock_d = relock_count + 8'd1;
                    end
                end
                S_ERROR: begin
                    if (start) begin
                        state_d = S_PHI_RST;
                        retry_d = 4'd0;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State, counters and output flops. The reset/status outputs are decoded
    // from the next state so they change on the same edge as the state itself.
    // The cycle counter restarts whenever the state changes; it wraps freely
    // in untimed states, where its value is never looked at.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q         <= S_IDLE;
            cycle_cnt       <= 20'd0;
            retry_count     <= 4'd0;
            relock_count    <= 8'd0;
            phi_pll_reset   <= 1'b1;
            theta_pll_reset <= 1'b1;
            tdc_reset       <= 1'b1;
            ready           <= 1'b0;
            error           <= 1'b0;
        end else begin
            state_q         <= state_d;
            cycle_cnt       <= (state_d != state_q) ? 20'd0 : cycle_cnt + 20'd1;
            retry_count     <= retry_d;
            relock_count    <= relock_d;
            phi_pll_reset   <= (state_d == S_IDLE) || (state_d == S_PHI_RST) ||
                               (state_d == S_ERROR);
            theta_pll_reset <= (state_d == S_IDLE) || (state_d == S_PHI_RST) ||
                               (state_d == S_PHI_WAIT) || (state_d == S_THETA_RST) ||
                               (state_d == S_ERROR);
            tdc_reset       <= (state_d != S_RUN);
            ready           <= (state_d == S_RUN);
            error           <= (state_d == S_ERROR);
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer
// Directed bring-up scenarios with randomized lock delays, retry counts and
// loss patterns. Expected durations come from a timeline model: each timed
// stage lasts its parameter in cycles, and a lock edge is acted on three
// observation cycles after it is driven (two synchronizer flops plus the
// state update). relock_count is tracked by a saturating scoreboard.
module tb_pll_reset_sequencer;

    localparam int RST     = 4;
    localparam int LOCK    = 100;
    localparam int TDC     = 8;
    localparam int RETRIES = 2;

    localparam logic [31:0] ST_IDLE       = 32'd0;
    localparam logic [31:0] ST_PHI_RST    = 32'd1;
    localparam logic [31:0] ST_PHI_WAIT   = 32'd2;
    localparam logic [31:0] ST_THETA_RST  = 32'd3;
    localparam logic [31:0] ST_THETA_WAIT = 32'd4;
    localparam logic [31:0] ST_TDC_RST    = 32'd5;
    localparam logic [31:0] ST_RUN        = 32'd6;
    localparam logic [31:0] ST_ERROR      = 32'd7;

    logic       clk_clk = 1'b0;
    logic       reset_reset_n;
    logic       start;
    logic       abort;
    logic       phi_locked;
    logic       theta_locked;
    logic       phi_pll_reset;
    logic       theta_pll_reset;
    logic       tdc_reset;
    logic       ready;
    logic       error;
    logic [2:0] state;
    logic [3:0] retry_count;
    logic [7:0] relock_count;

    int testCount = 0;
    int failCount = 0;
    int expRelock = 0;

    pll_reset_sequencer #(
        .RST_CYCLES    (RST),
        .LOCK_TIMEOUT  (LOCK),
        .TDC_RST_CYCLES(TDC),
        .MAX_RETRIES   (RETRIES)
    ) dut (
        .clk_clk        (clk_clk),
        .reset_reset_n  (reset_reset_n),
        .start          (start),
        .abort          (abort),
        .phi_locked     (phi_locked),
        .theta_locked   (theta_locked),
        .phi_pll_reset  (phi_pll_reset),
        .theta_pll_reset(theta_pll_reset),
        .tdc_reset      (tdc_reset),
        .ready          (ready),
        .error          (error),
        .state          (state),
        .retry_count    (retry_count),
        .relock_count   (relock_count)
    );

    // 50 MHz clock.
    always #10 clk_clk = ~clk_clk;

    // Hard stop in case the sequence gets stuck somewhere unexpected.
    initial begin
        #1_800_000;
        $display("[TB] FAIL watchdog: time budget exceeded, observed state %0d", state);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // One-cycle pulse on start/abort; returns at the negedge after it was sampled.
    task automatic applyStimulus(input logic s, input logic a);
        start = s;
        abort = a;
        @(negedge clk_clk);
        start = 1'b0;
        abort = 1'b0;
    endtask

    // Counts consecutive negedge observations of state s (bounded by limit).
    // On observation index setAt, raises phi (which=1) or theta (which=2).
    task automatic measureState(input logic [31:0] s, input int limit, input int setAt,
                                input int which, output int n);
        n = 0;
        while (32'(state) === s && n < limit) begin
            if (n == setAt) begin
                if (which == 1) phi_locked = 1'b1;
                else if (which == 2) theta_locked = 1'b1;
            end
            n++;
            @(negedge clk_clk);
        end
    endtask

    // Bring-up from IDLE/ERROR with locks low: k phi timeouts, then lock.
    // stopAt=1 returns on THETA_WAIT entry, 2 on TDC_RST entry, 0 runs to RUN.
    task automatic bringUp(input int k, input int stopAt);
        int n;
        int d;
        applyStimulus(1'b1, 1'b0);
        for (int p = 0; p <= k; p++) begin
            checkOutput("bringup_phi_rst_state", 32'(state), ST_PHI_RST);
            checkOutput("bringup_retry", 32'(retry_count), 32'(p));
            measureState(ST_PHI_RST, 50, -1, 0, n);
            checkOutput("phi_rst_len", 32'(n), 32'(RST));
            checkOutput("phi_wait_phi_reset", 32'(phi_pll_reset), 32'd0);
            checkOutput("phi_wait_theta_reset", 32'(theta_pll_reset), 32'd1);
            if (p < k) begin
                measureState(ST_PHI_WAIT, LOCK + 20, -1, 0, n);
                checkOutput("phi_timeout_len", 32'(n), 32'(LOCK));
            end else begin
                d = int'($urandom_range(0, 60));
                measureState(ST_PHI_WAIT, LOCK + 20, d, 1, n);
                checkOutput("phi_lock_len", 32'(n), 32'(d + 3));
            end
        end
        checkOutput("theta_rst_state", 32'(state), ST_THETA_RST);
        measureState(ST_THETA_RST, 50, -1, 0, n);
        checkOutput("theta_rst_len", 32'(n), 32'(RST));
        checkOutput("theta_wait_state", 32'(state), ST_THETA_WAIT);
        checkOutput("theta_wait_phi_reset", 32'(phi_pll_reset), 32'd0);
        checkOutput("theta_wait_theta_reset", 32'(theta_pll_reset), 32'd0);
        checkOutput("theta_wait_tdc_reset", 32'(tdc_reset), 32'd1);
        if (stopAt != 1) begin
            d = int'($urandom_range(0, 60));
            measureState(ST_THETA_WAIT, LOCK + 20, d, 2, n);
            checkOutput("theta_lock_len", 32'(n), 32'(d + 3));
            checkOutput("tdc_rst_state", 32'(state), ST_TDC_RST);
            if (stopAt != 2) begin
                measureState(ST_TDC_RST, 50, -1, 0, n);
                checkOutput("tdc_rst_len", 32'(n), 32'(TDC));
                checkOutput("run_state", 32'(state), ST_RUN);
                checkOutput("run_ready", 32'(ready), 32'd1);
                checkOutput("run_error", 32'(error), 32'd0);
                checkOutput("run_resets", {29'd0, phi_pll_reset, theta_pll_reset, tdc_reset}, 32'd0);
                checkOutput("run_retry", 32'(retry_count), 32'(k));
            end
        end
    endtask

    // From RUN with both locks high: drop one lock, check the reaction, then
    // restore it and check the time taken to get back to RUN.
    task automatic induceLoss(input int which);
        int n;
        logic [31:0] target;
        if (which == 1) phi_locked = 1'b0;
        else theta_locked = 1'b0;
        target = (which == 1) ? ST_PHI_RST : ST_THETA_RST;
        measureState(ST_RUN, 10, -1, 0, n);
        checkOutput("loss_latency", 32'(n), 32'd3);
        checkOutput("loss_target", 32'(state), target);
        expRelock = (expRelock >= 255) ? 255 : expRelock + 1;
        checkOutput("relock_count", 32'(relock_count), 32'(expRelock));
        checkOutput("loss_retry_cleared", 32'(retry_count), 32'd0);
        checkOutput("loss_tdc_reset", 32'(tdc_reset), 32'd1);
        checkOutput("loss_theta_reset", 32'(theta_pll_reset), 32'd1);
        checkOutput("loss_phi_reset", 32'(phi_pll_reset), (which == 1) ? 32'd1 : 32'd0);
        if (which == 1) phi_locked = 1'b1;
        else theta_locked = 1'b1;
        n = 0;
        while (32'(state) !== ST_RUN && n < 200) begin
            n++;
            @(negedge clk_clk);
        end
        checkOutput("relock_time", 32'(n), (which == 1) ? 32'(2 * RST + 2 + TDC) : 32'(RST + 1 + TDC));
        checkOutput("relock_ready", 32'(ready), 32'd1);
    endtask

    initial begin
        int n;
        int k;
        int w;
        reset_reset_n = 1'b0;
        start         = 1'b0;
        abort         = 1'b0;
        phi_locked    = 1'b0;
        theta_locked  = 1'b0;

        // Reset values.
        repeat (2) @(negedge clk_clk);
        checkOutput("reset_state", 32'(state), ST_IDLE);
        checkOutput("reset_resets", {29'd0, phi_pll_reset, theta_pll_reset, tdc_reset}, 32'd7);
        checkOutput("reset_ready", 32'(ready), 32'd0);
        checkOutput("reset_error", 32'(error), 32'd0);
        checkOutput("reset_retry", 32'(retry_count), 32'd0);
        checkOutput("reset_relock", 32'(relock_count), 32'd0);
        reset_reset_n = 1'b1;
        repeat (3) @(negedge clk_clk);
        checkOutput("idle_after_release", 32'(state), ST_IDLE);

        // Nominal bring-up with a random number of phi timeouts first.
        k = int'($urandom_range(0, RETRIES));
        bringUp(k, 0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("start_ignored_in_run", 32'(state), ST_RUN);

        // Theta loss, phi loss, then random losses up to 256 in total.
        induceLoss(2);
        induceLoss(1);
        for (int i = 2; i < 256; i++) induceLoss(int'($urandom_range(1, 2)));
        checkOutput("relock_saturated", 32'(relock_count), 32'd255);

        // abort from RUN, then abort+start together in THETA_WAIT.
        applyStimulus(1'b0, 1'b1);
        checkOutput("abort_run_state", 32'(state), ST_IDLE);
        checkOutput("abort_run_resets", {29'd0, phi_pll_reset, theta_pll_reset, tdc_reset}, 32'd7);
        phi_locked   = 1'b0;
        theta_locked = 1'b0;
        repeat (3) @(negedge clk_clk);
        bringUp(0, 1);
        w = int'($urandom_range(0, 50));
        repeat (w) @(negedge clk_clk);
        checkOutput("pre_abort_state", 32'(state), ST_THETA_WAIT);
        applyStimulus(1'b1, 1'b1);
        checkOutput("abort_beats_start", 32'(state), ST_IDLE);
        checkOutput("abort_resets", {29'd0, phi_pll_reset, theta_pll_reset, tdc_reset}, 32'd7);
        checkOutput("abort_ready", 32'(ready), 32'd0);

        // Phi never locks: RETRIES+1 passes, then ERROR.
        phi_locked = 1'b0;
        repeat (3) @(negedge clk_clk);
        applyStimulus(1'b1, 1'b0);
        for (int p = 0; p <= RETRIES; p++) begin
            checkOutput("nolock_state", 32'(state), ST_PHI_RST);
            checkOutput("nolock_retry", 32'(retry_count), 32'(p));
            measureState(ST_PHI_RST, 50, -1, 0, n);
            checkOutput("nolock_rst_len", 32'(n), 32'(RST));
            measureState(ST_PHI_WAIT, LOCK + 20, -1, 0, n);
            checkOutput("nolock_wait_len", 32'(n), 32'(LOCK));
        end
        checkOutput("error_state", 32'(state), ST_ERROR);
        checkOutput("error_flag", 32'(error), 32'd1);
        checkOutput("error_ready", 32'(ready), 32'd0);
        checkOutput("error_resets", {29'd0, phi_pll_reset, theta_pll_reset, tdc_reset}, 32'd7);
        checkOutput("error_retry", 32'(retry_count), 32'(RETRIES));
        repeat (int'($urandom_range(1, 20))) @(negedge clk_clk);
        checkOutput("error_held", 32'(state), ST_ERROR);
        applyStimulus(1'b1, 1'b0);
        checkOutput("error_restart_state", 32'(state), ST_PHI_RST);
        checkOutput("error_restart_retry", 32'(retry_count), 32'd0);
        checkOutput("error_restart_flag", 32'(error), 32'd0);
        applyStimulus(1'b0, 1'b1);
        checkOutput("abort_to_idle", 32'(state), ST_IDLE);

        // Asynchronous reset while in TDC_RST.
        repeat (3) @(negedge clk_clk);
        bringUp(int'($urandom_range(0, RETRIES)), 2);
        repeat (int'($urandom_range(0, TDC - 2))) @(negedge clk_clk);
        #3 reset_reset_n = 1'b0;
        #1;
        checkOutput("async_rst_state", 32'(state), ST_IDLE);
        checkOutput("async_rst_resets", {29'd0, phi_pll_reset, theta_pll_reset, tdc_reset}, 32'd7);
        checkOutput("async_rst_ready", 32'(ready), 32'd0);
        checkOutput("async_rst_error", 32'(error), 32'd0);
        checkOutput("async_rst_retry", 32'(retry_count), 32'd0);
        checkOutput("async_rst_relock", 32'(relock_count), 32'd0);
        @(negedge clk_clk);
        reset_reset_n = 1'b1;
        repeat (3) @(negedge clk_clk);
        checkOutput("post_rst_state", 32'(state), ST_IDLE);
        checkOutput("post_rst_relock", 32'(relock_count), 32'd0);
        checkOutput("post_rst_ready", 32'(ready), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
